// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL/MLA sequencer that borrows the shared ALU while busy.
// One multiplier bit per LOOP cycle; returns the low WIDTH product bits and N/Z flags.
module alu_mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             accumulate,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] Rm,
  input  logic [WIDTH-1:0] Rs,
  input  logic [WIDTH-1:0] Rn,
  input  logic             CF_in,
  input  logic             VF_in,
  input  logic [WIDTH-1:0] alu_F,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic             nzcv_we,
  output logic [1:0]       o_dbg_state
);
  // Handshake: start is a request level, accepted only on an edge where the
  // sequencer is IDLE; done is a single-cycle pulse qualifying result/nzcv.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_sflag;
  logic             w_last;

  // Last iteration: counter exhausted, or no multiplier bits left to consume.
  assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                  (EARLY_TERM && ((r_mplier >> 1) == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    alu_own      = 1'b0;
    alu_A        = '0;
    alu_B        = '0;
    alu_op       = OP_PASS;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_LOOP;
      end
      S_LOOP: begin
        alu_own = 1'b1;
        alu_A   = r_acc;
        alu_B   = r_mcand;
        alu_op  = r_mplier[0] ? OP_ADD : OP_PASS;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sflag  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= Rm;
            r_mplier <= Rs;
            r_acc    <= accumulate ? Rn : '0;
            r_sflag  <= set_flags;
            r_cnt    <= '0;
          end
        end
        S_LOOP: begin
          r_acc    <= alu_F;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Capture the final sum so result is already stable during DONE.
          if (w_last) r_result <= alu_F;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_LOOP) || (r_state == S_DONE);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign nzcv        = done ? {r_result[WIDTH-1], (r_result == '0), CF_in, VF_in} : 4'b0000;
  assign nzcv_we     = done & r_sflag;
  assign o_dbg_state = r_state;

endmodule
